// File: rtl/mem_responder_2p.sv
// Two-port memory responder: round-robin arbitration onto one single-ported byte array,
// one access per cycle, registered read data with a fixed 1-cycle latency per port.
module mem_responder_2p #(
  parameter int unsigned MEM_AW    = 16,
  parameter string       INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req1,
  input  logic        we1,
  input  logic [15:0] addr1,
  input  logic [7:0]  wdata1,
  output logic        gnt1,
  output logic        rvalid1,
  output logic [7:0]  rdata1,
  input  logic        req2,
  input  logic        we2,
  input  logic [15:0] addr2,
  input  logic [7:0]  wdata2,
  output logic        gnt2,
  output logic        rvalid2,
  output logic [7:0]  rdata2
);

  logic [7:0] mem [0:(1 << MEM_AW) - 1];

  // last_q: 0 = port 1 was granted last, 1 = port 2 was granted last
  logic              last_q;
  logic              sel_we;
  logic [MEM_AW-1:0] sel_idx;
  logic [7:0]        sel_wdata;
  logic              any_gnt;

  always_comb begin
    gnt1 = 1'b0;
    gnt2 = 1'b0;
    if (!rst) begin
      if (req1 && (!req2 || last_q)) gnt1 = 1'b1;
      else if (req2)                 gnt2 = 1'b1;
    end
  end

  always_comb begin
    any_gnt   = gnt1 | gnt2;
    sel_we    = gnt1 ? we1 : we2;
    sel_idx   = gnt1 ? addr1[MEM_AW-1:0] : addr2[MEM_AW-1:0];
    sel_wdata = gnt1 ? wdata1 : wdata2;
  end

  // Array is never reset; gnt is already low while rst is high, so no write slips through.
  always_ff @(posedge clk) begin
    if (any_gnt && sel_we) mem[sel_idx] <= sel_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q  <= 1'b1;
      rvalid1 <= 1'b0;
      rvalid2 <= 1'b0;
      rdata1  <= 8'h00;
      rdata2  <= 8'h00;
    end else begin
      rvalid1 <= gnt1 & ~we1;
      rvalid2 <= gnt2 & ~we2;
      if (gnt1) last_q <= 1'b0;
      if (gnt2) last_q <= 1'b1;
      if (gnt1 && !we1) rdata1 <= mem[sel_idx];
      if (gnt2 && !we2) rdata2 <= mem[sel_idx];
    end
  end

endmodule
